// File: rtl/seg_scan_mux.sv
// N-digit common-anode seven-segment scanner: hex decode, blanking, blinking,
// decimal points, PWM brightness and guard cycles between digit slots.
module seg_scan_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIV_W        = 16,
  parameter int BR_W         = 2,
  parameter int GUARD        = 1,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [NUM_DIGITS-1:0]   blink,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [BR_W-1:0]         brightness,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic                    frame_tick
);

  localparam int K_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [DIV_W-1:0] P_MAX   = '1;
  localparam logic [DIV_W-1:0] GUARD_P = DIV_W'(GUARD);
  localparam logic [K_W-1:0]   K_LAST  = K_W'(NUM_DIGITS - 1);
  localparam logic [FC_W-1:0]  FC_LAST = FC_W'(BLINK_FRAMES - 1);

  // Scan state
  logic [DIV_W-1:0] r_p;
  logic [K_W-1:0]   r_k;
  logic [FC_W-1:0]  r_fc;
  logic             r_blink_phase;

  // Per-slot latched digit attributes
  logic [3:0] r_s_digit;
  logic       r_s_blank;
  logic       r_s_blink;
  logic       r_s_dp;

  // Registered pin drivers
  logic [NUM_DIGITS-1:0] r_an;
  logic [6:0]            r_seg;
  logic                  r_dp_n;
  logic                  r_frame_tick;

  logic                  w_slot_start;
  logic                  w_slot_end;
  logic                  w_frame_end;
  logic [3:0]            w_live_digit;
  logic                  w_live_blank;
  logic                  w_live_blink;
  logic                  w_live_dp;
  logic [3:0]            w_cur_digit;
  logic                  w_cur_blank;
  logic                  w_cur_blink;
  logic                  w_cur_dp;
  logic [BR_W-1:0]       w_phase;
  logic                  w_on;
  logic [6:0]            w_seg_dec;
  logic [NUM_DIGITS-1:0] w_an;
  logic [6:0]            w_seg;
  logic                  w_dp_n;

  assign w_slot_start = (r_p == '0);
  assign w_slot_end   = (r_p == P_MAX);
  assign w_frame_end  = w_slot_end && (r_k == K_LAST);

  always_comb begin
    w_live_digit = 4'h0;
    w_live_blank = 1'b0;
    w_live_blink = 1'b0;
    w_live_dp    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_k == K_W'(i)) begin
        w_live_digit = digits[4*i +: 4];
        w_live_blank = blank[i];
        w_live_blink = blink[i];
        w_live_dp    = dp[i];
      end
    end
  end

  // The capture edge closes the p=0 cycle, so that cycle must see the live
  // inputs directly to keep the whole slot consistent with what is latched.
  assign w_cur_digit = w_slot_start ? w_live_digit : r_s_digit;
  assign w_cur_blank = w_slot_start ? w_live_blank : r_s_blank;
  assign w_cur_blink = w_slot_start ? w_live_blink : r_s_blink;
  assign w_cur_dp    = w_slot_start ? w_live_dp    : r_s_dp;

  assign w_phase = r_p[DIV_W-1 -: BR_W];

  assign w_on = (r_p >= GUARD_P) &&
                ((w_phase < brightness) || (brightness == '1)) &&
                !w_cur_blank &&
                !(w_cur_blink && r_blink_phase);

  // Bit order is {g,f,e,d,c,b,a}, active-low
  always_comb begin
    w_seg_dec = 7'h7f;
    unique case (w_cur_digit)
      4'h0: w_seg_dec = 7'h40;
      4'h1: w_seg_dec = 7'h79;
      4'h2: w_seg_dec = 7'h24;
      4'h3: w_seg_dec = 7'h30;
      4'h4: w_seg_dec = 7'h19;
      4'h5: w_seg_dec = 7'h12;
      4'h6: w_seg_dec = 7'h02;
      4'h7: w_seg_dec = 7'h78;
      4'h8: w_seg_dec = 7'h00;
      4'h9: w_seg_dec = 7'h10;
      4'ha: w_seg_dec = 7'h08;
      4'hb: w_seg_dec = 7'h03;
      4'hc: w_seg_dec = 7'h46;
      4'hd: w_seg_dec = 7'h21;
      4'he: w_seg_dec = 7'h06;
      4'hf: w_seg_dec = 7'h0e;
    endcase
  end

  always_comb begin
    w_an = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_on && (r_k == K_W'(i))) begin
        w_an[i] = 1'b0;
      end
    end
  end

  assign w_seg  = w_cur_blank ? 7'h7f : w_seg_dec;
  assign w_dp_n = w_cur_blank ? 1'b1 : ~w_cur_dp;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_p           <= '0;
      r_k           <= '0;
      r_fc          <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      r_p <= r_p + 1'b1;
      if (w_slot_end) begin
        r_k <= (r_k == K_LAST) ? '0 : r_k + 1'b1;
      end
      if (w_frame_end) begin
        if (r_fc == FC_LAST) begin
          r_fc          <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_fc <= r_fc + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s_digit <= 4'h0;
      r_s_blank <= 1'b0;
      r_s_blink <= 1'b0;
      r_s_dp    <= 1'b0;
    end else if (w_slot_start) begin
      r_s_digit <= w_live_digit;
      r_s_blank <= w_live_blank;
      r_s_blink <= w_live_blink;
      r_s_dp    <= w_live_dp;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_an         <= '1;
      r_seg        <= 7'h7f;
      r_dp_n       <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_an         <= w_an;
      r_seg        <= w_seg;
      r_dp_n       <= w_dp_n;
      r_frame_tick <= w_slot_start && (r_k == '0);
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp_n       = r_dp_n;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux: directed and random stimulus against a
// timeline model derived from the cycle count since reset release.
module tb_seg_scan_mux;

  localparam int N     = 4;
  localparam int DW    = 4;
  localparam int BW    = 2;
  localparam int G     = 1;
  localparam int BF    = 2;
  localparam int SLOT  = 1 << DW;
  localparam int FRAME = SLOT * N;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [4*N-1:0]  digits;
  logic [N-1:0]    blank;
  logic [N-1:0]    blink;
  logic [N-1:0]    dp;
  logic [BW-1:0]   brightness;
  logic [N-1:0]    an;
  logic [6:0]      seg;
  logic            dp_n;
  logic            frame_tick;

  seg_scan_mux #(
    .NUM_DIGITS  (N),
    .DIV_W       (DW),
    .BR_W        (BW),
    .GUARD       (G),
    .BLINK_FRAMES(BF)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .digits    (digits),
    .blank     (blank),
    .blink     (blink),
    .dp        (dp),
    .brightness(brightness),
    .an        (an),
    .seg       (seg),
    .dp_n      (dp_n),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int t     = 0;
  int mode  = 0;

  // Decode table written in abcdefg order as a string of segment states
  logic [0:6] hex_abc [16];

  logic [3:0]   m_dig;
  logic         m_blank, m_blink, m_dp;
  logic         have_exp = 1'b0;
  logic [N-1:0] exp_an;
  logic [6:0]   exp_seg;
  logic         exp_dpn, exp_ft;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic check_pending();
    if (have_exp) begin
      check_eq("an", 32'(an), 32'(exp_an));
      check_eq("seg", 32'(seg), 32'(exp_seg));
      check_eq("dp_n", 32'(dp_n), 32'(exp_dpn));
      check_eq("frame_tick", 32'(frame_tick), 32'(exp_ft));
    end
  endtask

  task automatic check_dark(input string tag);
    check_eq({tag, "_an"}, 32'(an), 32'({N{1'b1}}));
    check_eq({tag, "_seg"}, 32'(seg), 32'h7f);
    check_eq({tag, "_dp_n"}, 32'(dp_n), 32'd1);
    check_eq({tag, "_ft"}, 32'(frame_tick), 32'd0);
  endtask

  // Expected registered outputs for the scan state at cycle t
  task automatic model_step();
    int p, k, bp, ph;
    bit on;
    logic [0:6] abc;
    p  = t % SLOT;
    k  = (t / SLOT) % N;
    bp = (t / FRAME / BF) % 2;
    if (p == 0) begin
      m_dig   = digits[4*k +: 4];
      m_blank = blank[k];
      m_blink = blink[k];
      m_dp    = dp[k];
    end
    ph = p / (SLOT >> BW);
    on = (p >= G) && ((ph < int'(brightness)) || (brightness == {BW{1'b1}})) &&
         !m_blank && !(m_blink && bp == 1);
    exp_an = '1;
    if (on) exp_an[k] = 1'b0;
    abc = hex_abc[m_dig];
    for (int i = 0; i < 7; i++) exp_seg[i] = abc[i];
    if (m_blank) exp_seg = 7'h7f;
    exp_dpn  = m_blank ? 1'b1 : ~m_dp;
    exp_ft   = (p == 0) && (k == 0);
    have_exp = 1'b1;
  endtask

  task automatic cycle();
    check_pending();
    if (mode == 1) begin
      if ($urandom_range(3) == 0) digits = 16'($urandom);
      if ($urandom_range(3) == 0) dp = 4'($urandom);
      if ($urandom_range(7) == 0) blank = 4'($urandom & $urandom);
      if ($urandom_range(7) == 0) blink = 4'($urandom);
      if ($urandom_range(7) == 0) brightness = 2'($urandom);
    end
    model_step();
    t++;
    @(negedge clk);
  endtask

  task automatic reset_mid_slot();
    check_pending();
    have_exp = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check_dark("rst_async");
    @(negedge clk);
    check_dark("rst_hold");
    reset = 1'b1;
    t = 0;
  endtask

  initial begin
    hex_abc[0]  = 7'b0000001; hex_abc[1]  = 7'b1001111;
    hex_abc[2]  = 7'b0010010; hex_abc[3]  = 7'b0000110;
    hex_abc[4]  = 7'b1001100; hex_abc[5]  = 7'b0100100;
    hex_abc[6]  = 7'b0100000; hex_abc[7]  = 7'b0001111;
    hex_abc[8]  = 7'b0000000; hex_abc[9]  = 7'b0000100;
    hex_abc[10] = 7'b0001000; hex_abc[11] = 7'b1100000;
    hex_abc[12] = 7'b0110001; hex_abc[13] = 7'b1000010;
    hex_abc[14] = 7'b0110000; hex_abc[15] = 7'b0111000;
    m_dig = 4'h0; m_blank = 1'b0; m_blink = 1'b0; m_dp = 1'b0;
    exp_an = '1; exp_seg = 7'h7f; exp_dpn = 1'b1; exp_ft = 1'b0;

    digits = 16'h4321; blank = '0; blink = '0; dp = '0; brightness = 2'd3;
    repeat (3) @(negedge clk);
    check_dark("reset");
    reset = 1'b1;
    t = 0;

    // Full brightness walk through every digit
    repeat (2 * FRAME) cycle();
    brightness = 2'd1;
    repeat (FRAME) cycle();
    brightness = 2'd0;
    repeat (FRAME) cycle();

    // Every hex code on digit 0, with its decimal point lit
    brightness = 2'd3;
    dp = 4'b0001;
    for (int v = 0; v < 16; v++) begin
      digits[3:0] = 4'(v);
      repeat (FRAME) cycle();
    end

    dp = 4'b0010;
    blank = 4'b0010;
    repeat (FRAME) cycle();

    blank = '0;
    dp = '0;
    blink = 4'b0001;
    repeat (6 * FRAME) cycle();

    mode = 1;
    repeat (1500) cycle();

    // Reset in the middle of slot 2, then retire the pending check first
    mode = 0;
    digits = 16'h4321; blank = '0; blink = '0; dp = '0; brightness = 2'd3;
    for (int i = 0; i < FRAME && (t % FRAME) != 2 * SLOT + 8; i++) cycle();
    reset_mid_slot();

    // Mid-slot digit change must not tear slot 0
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (i == 8) digits = 16'hbeef;
      cycle();
    end
    check_pending();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Parametrised successor to the fixed four-digit display multiplexer used on the ready-set-go board.
- Drives an N-digit common-anode seven-segment display from packed hex nibbles.
- Includes hex decode, per-digit blanking, per-digit blinking, decimal points, PWM brightness and anti-ghosting guard cycles.
- Sits between game/sequencer logic (countdown, score, pattern display) and the board's an/seg/dp pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
DIV_W, 16, slot prescaler width; each digit slot lasts 2^DIV_W clk cycles
BR_W, 2, brightness width; slot is split into 2^BR_W PWM phases
GUARD, 1, cycles at the start of each slot with all anodes off (0..2^(DIV_W-BR_W)-1)
BLINK_FRAMES, 64, full scan frames per blink half-period (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
digits  in  4*NUM_DIGITS  hex value per digit; digit i = digits[4i+3:4i]
blank  in  NUM_DIGITS  1 = digit i dark
blink  in  NUM_DIGITS  1 = digit i blinks
dp  in  NUM_DIGITS  1 = decimal point i lit
brightness  in  BR_W  PWM duty; 0 = off, all-ones = full on
an  out  NUM_DIGITS  anode enables, active-low
seg  out  7  segments seg[0]=a .. seg[6]=g, active-low
dp_n  out  1  decimal point, active-low
frame_tick  out  1  one-cycle pulse when digit index wraps NUM_DIGITS-1 -> 0

Behaviour:
- Reset (reset=0, async): an=all 1, seg=7'b1111111, dp_n=1, frame_tick=0; prescaler, digit index, frame counter and blink_phase cleared to 0. Outputs hold these values until the first clk edge after reset deasserts.
- Prescaler p counts 0..2^DIV_W-1 every clk and wraps.
- On the wrap, digit index k advances; k=NUM_DIGITS-1 goes to 0.
- Slot capture:
  - At p=0, latch digits/blank/blink/dp for the new k into slot registers.
  - Input changes mid-slot do not affect the current slot (no tearing).
- Enable rule. Let phase = p[DIV_W-1 -: BR_W]. Digit k is on iff all of:
  - p >= GUARD
  - (phase < brightness) OR (brightness == all-ones)
  - latched blank = 0
  - NOT (latched blink = 1 AND blink_phase = 1)
- When on: an[k]=0 and all other an bits = 1.
- When off: an = all 1; seg and dp_n still show the decoded value (don't-care electrically, but defined for the bench).
- Hex decode, seg[0:6] = abcdefg, active-low:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- When latched blank=1: seg=1111111 and dp_n=1.
- dp_n = ~latched dp, gated by blank.
- Latency: an/seg/dp_n are registered. Values computed from state at cycle t appear at t+1, so a slot change on p wrap is visible one cycle later. This lag is uniform across all outputs.
- frame_tick: high exactly one cycle, coincident with the first registered output of digit 0's slot.
- Blink:
  - The frame counter increments on each frame wrap.
  - On reaching BLINK_FRAMES-1 it clears and blink_phase toggles.
  - Blink-off half-periods therefore last BLINK_FRAMES frames exactly.
- Boundaries:
  - NUM_DIGITS=1: k stays 0 and frame_tick pulses every slot.
  - brightness change mid-slot takes effect from the next cycle (not latched).
  - Reset mid-slot: immediate dark outputs; the scan restarts at digit 0, p=0.

Test Plan:
- NUM_DIGITS=4, DIV_W=4, BR_W=2, GUARD=1, brightness=3, digits=16'h4321, no blank/blink/dp -> slot 0:
  - cycle 1 after slot start: an=1111
  - cycles 2..16: an=1110, seg=1001111
  - slots 1..3 show 2,3,4 on an=1101,1011,0111 in order
  - frame_tick pulses once per 64 cycles.
- Same config, brightness=1 -> in each slot an active only while p in 1..3 (phase 0 minus guard), 3 of 16 cycles; brightness=0 -> an stays 1111.
- All 16 hex codes via digit 0 -> seg matches the decode table above; dp[0]=1 gives dp_n=0 during slot 0 only.
- blank=4'b0010 -> slot 1: an=1111, seg=1111111, dp_n=1 even with dp[1]=1; other digits unaffected.
- BLINK_FRAMES=2, blink=4'b0001 -> digit 0 lit for frames 0-1, dark for frames 2-3, lit for frames 4-5; digits 1-3 always lit.
- Change digits at p=8 of slot 0 -> slot 0 output unchanged. Assert reset at p=8 of slot 2 -> an=1111 and seg=1111111 immediately (async). After release, the first lit digit is digit 0 at cycle 2 (guard cycle 1).
